cp0_ctrl: RTL
=============

// Module: cp0_ctrl
// PURPOSE
//   Coprocessor-0 exception/interrupt controller; the counterpart that consumes the fetch AdEL flag and drives the PC redirect (req, EBase).
//   Sits in the M stage: takes the merged exception code, BD flag and victim PC from the pipeline, plus HWInt[5:0] from the bridge.
//   Holds SR/Cause/EPC, serves mtc0/mfc0, raises req, and supplies EPC for eret.
// PARAMETERS
//   EBASE  32'h0000_4180  handler entry address driven on ebase
//   PRID   32'h2022_0007  read-only value returned for reg 15
// PORTS
//   clk       in   1   clock, rising edge
//   reset     in   1   synchronous, active-high
//   en        in   1   mtc0 write enable (M-stage instr is mtc0)
//   addr      in   5   CP0 register number for mtc0/mfc0 (rd field)
//   wdata     in   32  mtc0 write data
//   vpc       in   32  PC of the M-stage (victim) instruction
//   bd_in     in   1   victim is in a branch delay slot
//   exc_in    in   5   merged ExcCode of victim, 0 = none
//   hwint     in   6   hardware interrupt lines, level-sensitive
//   eret      in   1   M-stage instr is eret
//   rdata     out  32  mfc0 read data, combinational
//   req       out  1   take exception/interrupt now; flushes pipe, PC <= ebase
//   ebase     out  32  constant EBASE
//   epc_out   out  32  current EPC, PC target on eret
// BEHAVIOUR
//   Registers:
//     SR(12): IM[15:10], EXL[1], IE[0]; other bits read 0.
//     Cause(13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0.
//     EPC(14): 32 bits.
//     PRId(15): PRID constant.
//   Reset: SR, Cause and EPC all 0; req forced 0 while reset high; rdata follows regs (0).
//   Request logic (combinational):
//     int_req = |(hwint & SR.IM) & SR.IE & ~SR.EXL
//     exc_req = (exc_in != 0) & ~SR.EXL
//     req = (int_req | exc_req) & ~reset
//   Interrupt has priority over exception: ExcCode written as 0 when int_req.
//   On posedge with req=1:
//     EXL <= 1; Cause.BD <= bd_in; Cause.ExcCode <= int_req ? 0 : exc_in
//     EPC <= bd_in ? {vpc[31:2],2'b0} - 4 : {vpc[31:2],2'b0}
//     mtc0 and eret in the same cycle are suppressed.
//   Cause.IP <= hwint on every non-reset edge, independent of req.
//   mtc0 (en & ~req): addr 12 writes SR masked bits; addr 14 writes EPC; addr 13/15/other are ignored.
//   eret (eret & ~req): EXL <= 0 at the edge; epc_out is valid the same cycle for the PC mux.
//   Simultaneous mtc0 to EPC and eret is impossible (same stage); if both are asserted, the write wins and EXL is cleared.
//   rdata: addr 12/13/14/15 -> SR/Cause/EPC/PRId masked views; any other addr -> 0. No forwarding of same-cycle writes.
//   Latency: req is same-cycle combinational; state updates 1 edge later.
//   Reset mid-handler clears EXL; hwint is re-sampled normally afterwards.
//   Nested events while EXL=1: no req, no update to EPC/Cause.ExcCode/BD.
// STRUCTURE
//   Shared package cp0_defs:
//     Register numbers: SR 12, CAUSE 13, EPC 14, PRID 15.
//     ExcCodes: INT 0, ADEL 4, ADES 5, SYSCALL 8, RI 10, OV 12.
//     SR/Cause field bit positions.
//   Single module; no sub-module needed (priority logic and the register file are both small).
// TESTING
//   1. reset=1 for 2 cycles -> SR, Cause and EPC read 0; req=0 even with exc_in=4.
//   2. exc_in=4 (AdEL), vpc=32'h3003, bd_in=0 -> req=1 same cycle; next: EPC=3000, ExcCode=4, EXL=1.
//   3. mtc0 SR=32'h0000_fc01, hwint=6'b000100, bd_in=1, vpc=32'h3010:
//        -> req=1, ExcCode=0, EPC=300c, BD=1, IP=000100.
//   4. EXL=1 with exc_in=12 and hwint=6'h3f -> req=0; EPC unchanged; eret -> EXL=0 next edge, epc_out=EPC.
//   5. exc_in=10 together with mtc0 EPC=32'h5000 -> req=1; EPC=vpc, not 5000.
//   6. mtc0 to addr 13 with 32'hffff_ffff -> Cause unchanged; mfc0 addr 15 -> PRID; addr 3 -> 0.

Source files
------------

// File: rtl/cp0_defs.sv
// rtl/cp0_defs.sv - shared CP0 register numbers, exception codes and field positions
package cp0_defs;

    // CP0 register numbers as they appear in the rd field of mtc0/mfc0
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;

    // SR field positions
    localparam int SR_IE_BIT     = 0;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IM_LSB     = 10;

    // Cause field positions
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_IP_LSB  = 10;
    localparam int CAUSE_BD_BIT  = 31;

endpackage

// File: rtl/cp0_ctrl.sv
// rtl/cp0_ctrl.sv - coprocessor-0 exception/interrupt controller (SR/Cause/EPC/PRId)
//
// Sits in the M stage. Decides whether to take an exception or interrupt this
// cycle (req, combinational), records the victim state, serves mtc0/mfc0 and
// supplies EPC as the eret target.
//
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous, active-high
//   en       : mtc0 write enable
//   addr     : CP0 register number for mtc0/mfc0
//   wdata    : mtc0 write data
//   vpc      : PC of the victim instruction
//   bd_in    : victim sits in a branch delay slot
//   exc_in   : merged ExcCode of the victim, 0 = none
//   hwint    : level-sensitive hardware interrupt lines
//   eret     : M-stage instruction is eret
//   rdata    : mfc0 read data (combinational, no same-cycle forwarding)
//   req      : take exception/interrupt now
//   ebase    : handler entry address
//   epc_out  : current EPC, PC target on eret
module cp0_ctrl
    import cp0_defs::*;
#(
    parameter logic [31:0] EBASE = 32'h0000_4180,
    parameter logic [31:0] PRID  = 32'h2022_0007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_in,
    input  logic [5:0]  hwint,
    input  logic        eret,
    output logic [31:0] rdata,
    output logic        req,
    output logic [31:0] ebase,
    output logic [31:0] epc_out
);

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic [31:0] vpc_word;
    logic [31:0] sr_view;
    logic [31:0] cause_view;

    assign int_req = (|(hwint & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req = (exc_in != 5'd0) & ~sr_exl;
    assign req     = (int_req | exc_req) & ~reset;

    // Victim PC aligned to a word; a delay-slot victim restarts at its branch
    assign vpc_word = vpc & 32'hFFFF_FFFC;

    assign ebase   = EBASE;
    assign epc_out = epc;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= hwint;
            if (req) begin
                // mtc0/eret in the same cycle are squashed with the victim
                sr_exl    <= 1'b1;
                cause_bd  <= bd_in;
                cause_exc <= int_req ? EXC_INT : exc_in;
                epc       <= bd_in ? vpc_word - 32'd4 : vpc_word;
            end else begin
                if (en) begin
                    if (addr == REG_SR) begin
                        sr_im  <= wdata[SR_IM_LSB +: 6];
                        sr_exl <= wdata[SR_EXL_BIT];
                        sr_ie  <= wdata[SR_IE_BIT];
                    end else if (addr == REG_EPC) begin
                        epc <= wdata;
                    end
                end
                // eret after any SR write so EXL always ends up cleared
                if (eret) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        sr_view                              = '0;
        sr_view[SR_IM_LSB +: 6]              = sr_im;
        sr_view[SR_EXL_BIT]                  = sr_exl;
        sr_view[SR_IE_BIT]                   = sr_ie;

        cause_view                           = '0;
        cause_view[CAUSE_BD_BIT]             = cause_bd;
        cause_view[CAUSE_IP_LSB +: 6]        = cause_ip;
        cause_view[CAUSE_EXC_LSB +: 5]       = cause_exc;

        case (addr)
            REG_SR:    rdata = sr_view;
            REG_CAUSE: rdata = cause_view;
            REG_EPC:   rdata = epc;
            REG_PRID:  rdata = PRID;
            default:   rdata = '0;
        endcase
    end

endmodule
